reaction_controller: RTL and testbench
======================================

REACTION_CONTROLLER -- requirements
Module: reaction_controller

Interface
REQ-001 Parameter WAIT_MIN_MS, default 1000: minimum random pre-stimulus delay, ms.
REQ-002 Parameter WAIT_MASK, default 14'h0FFF: mask applied to the LFSR to form the extra delay, ms.
REQ-003 Parameter TIMEOUT_MS, default 9999: maximum measurable reaction time, ms.
REQ-004 clock  in  1  system clock; sole clock; all state on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 rising_edge_1khz  in  1  one-clock strobe at 1 kHz; the millisecond tick.
REQ-007 start_btn  in  1  debounced start/restart button, level.
REQ-008 react_btn  in  1  debounced reaction button, level.
REQ-009 time_millisecs  out  14  value or display code for the SSD decoder.
REQ-010 display_enable  out  1  SSD anode enable.
REQ-011 stimulus_led  out  1  high while the user must react.

Function
REQ-012 Each button SHALL be rising-edge detected internally (registered previous level); a "press" is one clock where level=1 and previous=0.
REQ-013 Display codes SHALL be the shared defines `IDLE, `FAIL, `LED_BLANK; numeric results SHALL be 0..TIMEOUT_MS.
REQ-014 FSM states SHALL be S_IDLE, S_COUNT, S_WAIT, S_MEASURE, S_RESULT, S_FAIL.
REQ-015 S_IDLE: output `IDLE, stimulus_led=0; start press -> S_COUNT, countdown counter loaded with 3000.
REQ-016 S_COUNT: output (counter/1000 rounded up)*1000, i.e. 3000/2000/1000; counter decrements per tick; react press -> S_FAIL; reaching 0 -> S_WAIT, delay loaded with WAIT_MIN_MS + (lfsr & WAIT_MASK).
REQ-017 S_WAIT: output `LED_BLANK; delay decrements per tick; react press before delay=0 -> S_FAIL; delay=0 -> S_MEASURE, ms counter cleared, stimulus_led=1 from the next clock.
REQ-018 S_MEASURE: output live ms counter; counter increments per tick; react press -> S_RESULT, counter frozen; counter reaching TIMEOUT_MS without press -> S_FAIL.
REQ-019 A react press and a tick in the same clock in S_MEASURE SHALL freeze the pre-increment value.
REQ-020 S_RESULT: output frozen value, stimulus_led=0; start press -> S_COUNT; react press ignored.
REQ-021 S_FAIL: output `FAIL, stimulus_led=0; start press -> S_COUNT.
REQ-022 Start press in S_COUNT, S_WAIT or S_MEASURE SHALL abort to S_IDLE; start takes priority over react in the same clock.
REQ-023 A 16-bit maximal-length LFSR (taps 16,15,13,4), seed 16'hACE1, SHALL advance every clock in all states; an all-zero state is unreachable.
REQ-024 display_enable SHALL be 1 in every state except reset.
REQ-025 All outputs SHALL be registered; state change visible on outputs one clock after the triggering edge/strobe.

Reset
REQ-026 On reset: state S_IDLE, time_millisecs=`IDLE, display_enable=0, stimulus_led=0, all counters 0, button history 0, LFSR 16'hACE1.
REQ-027 Reset asserted mid-operation SHALL abandon the round immediately; no result is retained except per REQ-029.

Configuration
REQ-028 Macro BEST_TIME_EN absent: S_IDLE always outputs `IDLE.
REQ-029 Macro BEST_TIME_EN defined: a best-time register (reset 14'h3FFF = none) SHALL capture any strictly lower S_RESULT value on entry to S_RESULT; S_IDLE SHALL output the best time when one exists, else `IDLE; reset clears it.

Verification
REQ-030 Reset then idle 5 ms -> time_millisecs=`IDLE, stimulus_led=0, display_enable=1 after release.
REQ-031 Start press, no react -> outputs 3000,2000,1000 for 1000 ticks each, then `LED_BLANK, then stimulus_led=1 after WAIT_MIN_MS+(lfsr&WAIT_MASK) ticks.
REQ-032 React press during S_WAIT -> `FAIL next clock, stimulus_led stays 0; start press -> 3000.
REQ-033 React press 250 ticks after stimulus -> time_millisecs=250 held, stimulus_led=0; further react presses leave 250.
REQ-034 No react for 9999 ticks after stimulus -> `FAIL; react press and tick in same clock at count 412 -> 412.
REQ-035 BEST_TIME_EN: results 300 then 450, abort to S_IDLE -> S_IDLE shows 300; reset -> `IDLE.

Source files
------------

// File: rtl/reaction_controller.sv
// Reaction-time game: 3-2-1 countdown, random blanked delay, lit stimulus, then the measured
// response in ms on the SSD. Define BEST_TIME_EN to keep the best result and show it while idle.

`ifndef IDLE
`define IDLE 14'd10000
`endif
`ifndef FAIL
`define FAIL 14'd10001
`endif
`ifndef LED_BLANK
`define LED_BLANK 14'd10002
`endif

module reaction_controller #(
  parameter int unsigned WAIT_MIN_MS = 1000,
  parameter logic [13:0] WAIT_MASK   = 14'h0FFF,
  parameter int unsigned TIMEOUT_MS  = 9999
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        rising_edge_1khz,
  input  logic        start_btn,
  input  logic        react_btn,
  output logic [13:0] time_millisecs,
  output logic        display_enable,
  output logic        stimulus_led
);

  typedef enum logic [2:0] {S_IDLE, S_COUNT, S_WAIT, S_MEASURE, S_RESULT, S_FAIL} state_t;

  localparam logic [13:0] TimeoutLast = 14'(TIMEOUT_MS - 1);

  state_t      state_q;
  logic [13:0] count_q;  // countdown, random delay or elapsed ms, depending on state
  logic [15:0] lfsr_q;
  logic        start_prev_q, react_prev_q;

  logic        start_press, react_press, tick;
  logic [15:0] lfsr_next;
  logic [13:0] wait_load, count_dec, count_disp, idle_code;

  assign start_press = start_btn & ~start_prev_q;
  assign react_press = react_btn & ~react_prev_q;
  assign tick        = rising_edge_1khz;
  assign lfsr_next   = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[14] ^ lfsr_q[12] ^ lfsr_q[3]};
  assign wait_load   = 14'(WAIT_MIN_MS) + (lfsr_q[13:0] & WAIT_MASK);

  // Countdown shows the remaining time rounded up to whole seconds.
  always_comb begin
    count_dec = count_q - 14'd1;
    if (count_dec > 14'd2000) begin
      count_disp = 14'd3000;
    end else if (count_dec > 14'd1000) begin
      count_disp = 14'd2000;
    end else begin
      count_disp = 14'd1000;
    end
  end

`ifdef BEST_TIME_EN
  localparam logic [13:0] NoBest = 14'h3FFF;
  logic [13:0] best_q;
  assign idle_code = (best_q == NoBest) ? `IDLE : best_q;
`else
  assign idle_code = `IDLE;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      count_q        <= '0;
      lfsr_q         <= 16'hACE1;
      start_prev_q   <= 1'b0;
      react_prev_q   <= 1'b0;
      time_millisecs <= `IDLE;
      display_enable <= 1'b0;
      stimulus_led   <= 1'b0;
`ifdef BEST_TIME_EN
      best_q         <= NoBest;
`endif
    end else begin
      start_prev_q   <= start_btn;
      react_prev_q   <= react_btn;
      lfsr_q         <= lfsr_next;
      display_enable <= 1'b1;
      unique case (state_q)
        S_IDLE: begin
          if (start_press) begin
            state_q        <= S_COUNT;
            count_q        <= 14'd3000;
            time_millisecs <= 14'd3000;
          end
        end
        S_COUNT: begin
          if (start_press) begin
            state_q        <= S_IDLE;
            time_millisecs <= idle_code;
          end else if (react_press) begin
            state_q        <= S_FAIL;
            time_millisecs <= `FAIL;
          end else if (tick) begin
            if (count_q <= 14'd1) begin
              state_q        <= S_WAIT;
              count_q        <= wait_load;
              time_millisecs <= `LED_BLANK;
            end else begin
              count_q        <= count_dec;
              time_millisecs <= count_disp;
            end
          end
        end
        S_WAIT: begin
          if (start_press) begin
            state_q        <= S_IDLE;
            time_millisecs <= idle_code;
          end else if (react_press) begin
            state_q        <= S_FAIL;
            time_millisecs <= `FAIL;
          end else if (tick) begin
            if (count_q <= 14'd1) begin
              state_q        <= S_MEASURE;
              count_q        <= '0;
              time_millisecs <= '0;
              stimulus_led   <= 1'b1;
            end else begin
              count_q <= count_dec;
            end
          end
        end
        S_MEASURE: begin
          // A press wins over a coincident tick, so the pre-increment value is kept.
          if (start_press) begin
            state_q        <= S_IDLE;
            time_millisecs <= idle_code;
            stimulus_led   <= 1'b0;
          end else if (react_press) begin
            state_q        <= S_RESULT;
            time_millisecs <= count_q;
            stimulus_led   <= 1'b0;
`ifdef BEST_TIME_EN
            if (count_q < best_q) best_q <= count_q;
`endif
          end else if (tick) begin
            if (count_q >= TimeoutLast) begin
              state_q        <= S_FAIL;
              time_millisecs <= `FAIL;
              stimulus_led   <= 1'b0;
            end else begin
              count_q        <= count_q + 14'd1;
              time_millisecs <= count_q + 14'd1;
            end
          end
        end
        S_RESULT, S_FAIL: begin
          if (start_press) begin
            state_q        <= S_COUNT;
            count_q        <= 14'd3000;
            time_millisecs <= 14'd3000;
          end
        end
        default: begin
          state_q        <= S_IDLE;
          time_millisecs <= idle_code;
          stimulus_led   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reaction_controller.sv
// Randomized bench for reaction_controller: a behavioural game model checked every cycle,
// plus literal expectations at the countdown, stimulus, timeout and same-clock boundaries.

module tb_reaction_controller;

  localparam int unsigned WaitMin   = 1000;
  localparam logic [13:0] WaitMask  = 14'h0FFF;
  localparam int unsigned Timeout   = 9999;
  localparam int          IdleCode  = 10000;
  localparam int          FailCode  = 10001;
  localparam int          BlankCode = 10002;
  localparam int          NoBest    = 16383;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        rising_edge_1khz = 1'b0;
  logic        start_btn = 1'b0;
  logic        react_btn = 1'b0;
  logic [13:0] time_millisecs;
  logic        display_enable;
  logic        stimulus_led;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  reaction_controller #(
    .WAIT_MIN_MS(WaitMin),
    .WAIT_MASK  (WaitMask),
    .TIMEOUT_MS (Timeout)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .rising_edge_1khz(rising_edge_1khz),
    .start_btn       (start_btn),
    .react_btn       (react_btn),
    .time_millisecs  (time_millisecs),
    .display_enable  (display_enable),
    .stimulus_led    (stimulus_led)
  );

  always #5 clock = ~clock;

  // Game model: phase plus "ms left" / "ms elapsed"; display derived from the rules.
  typedef enum {M_IDLE, M_COUNT, M_WAIT, M_MEASURE, M_RESULT, M_FAIL} mst_t;
  typedef struct {
    mst_t        st;
    int          left;
    int          ms;
    int          best;
    logic [15:0] lfsr;
    bit          sp, rp;
    int          disp;
    bit          led, en;
  } model_t;

  model_t m;

  function automatic model_t model_reset();
    model_t n;
    n.st = M_IDLE; n.left = 0; n.ms = 0; n.best = NoBest; n.lfsr = 16'hACE1;
    n.sp = 0; n.rp = 0; n.disp = IdleCode; n.led = 0; n.en = 0;
    return n;
  endfunction

  function automatic model_t model_step(model_t c, bit s, bit r, bit t);
    model_t n = c;
    bit sp = s && !c.sp;
    bit rp = r && !c.rp;
    n.sp = s;
    n.rp = r;
    case (c.st)
      M_COUNT, M_WAIT: begin
        if (sp) n.st = M_IDLE;
        else if (rp) n.st = M_FAIL;
        else if (t) begin
          n.left = c.left - 1;
          if (n.left <= 0 && c.st == M_COUNT) begin
            n.st = M_WAIT;
            n.left = int'(WaitMin) + int'(c.lfsr[13:0] & WaitMask);
          end else if (n.left <= 0) begin
            n.st = M_MEASURE;
            n.ms = 0;
          end
        end
      end
      M_MEASURE: begin
        if (sp) n.st = M_IDLE;
        else if (rp) begin
          n.st = M_RESULT;
`ifdef BEST_TIME_EN
          if (c.ms < c.best) n.best = c.ms;
`endif
        end else if (t) begin
          n.ms = c.ms + 1;
          if (n.ms >= int'(Timeout)) n.st = M_FAIL;
        end
      end
      default: begin
        if (sp) begin
          n.st = M_COUNT;
          n.left = 3000;
        end
      end
    endcase
    n.lfsr = {c.lfsr[14:0], c.lfsr[15] ^ c.lfsr[14] ^ c.lfsr[12] ^ c.lfsr[3]};
    n.en = 1;
    n.led = (n.st == M_MEASURE);
    case (n.st)
      M_IDLE:    n.disp = (n.best != NoBest) ? n.best : IdleCode;
      M_COUNT:   n.disp = ((n.left + 999) / 1000) * 1000;
      M_WAIT:    n.disp = BlankCode;
      M_FAIL:    n.disp = FailCode;
      default:   n.disp = n.ms;
    endcase
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m <= model_reset();
    else m <= model_step(m, start_btn, react_btn, rising_edge_1khz);
  end

  always @(negedge clock) begin
    if (chk_on) begin
      vectors++;
      if (time_millisecs !== 14'(m.disp) || stimulus_led !== m.led || display_enable !== m.en) begin
        miscompares++;
        $display("FAIL cycle_compare t=%0t: got time=%0d led=%b en=%b, want time=%0d led=%b en=%b",
                 $time, time_millisecs, stimulus_led, display_enable, m.disp, m.led, m.en);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input bit s, input bit r, input bit t);
    start_btn = s;
    react_btn = r;
    rising_edge_1khz = t;
    @(posedge clock);
    #1;
  endtask

  function automatic bit rtick();
    return $urandom_range(0, 9) != 0;
  endfunction

  task automatic run_until(input mst_t target, input int budget);
    int n = 0;
    while (m.st != target && n < budget) begin
      cyc(0, 0, rtick());
      n++;
    end
    if (m.st != target) begin
      vectors++;
      miscompares++;
      $display("FAIL run_until %s: still %s after %0d cycles", target.name(), m.st.name(), n);
    end
  endtask

  task automatic run_to_ms(input int target);
    int n = 0;
    while (m.ms < target && m.st == M_MEASURE && n < 20000) begin
      cyc(0, 0, rtick());
      n++;
    end
  endtask

  int delay;

  initial begin
    #3 reset = 1'b1;
    chk_on = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("reset_time", 32'(time_millisecs), IdleCode);
    chk("reset_en", 32'(display_enable), 0);
    chk("reset_led", 32'(stimulus_led), 0);
    reset = 1'b0;
    repeat (5) cyc(0, 0, 1);
    chk("idle_time", 32'(time_millisecs), IdleCode);
    chk("idle_en", 32'(display_enable), 1);
    chk("idle_led", 32'(stimulus_led), 0);

    // Full round: exact countdown boundaries, stimulus after the random delay, 250 ms result.
    cyc(1, 0, 0);
    chk("count_entry", 32'(time_millisecs), 3000);
    repeat (999) cyc(0, 0, 1);
    chk("count_999", 32'(time_millisecs), 3000);
    cyc(0, 0, 1);
    chk("count_1000", 32'(time_millisecs), 2000);
    repeat (1000) cyc(0, 0, 1);
    chk("count_2000", 32'(time_millisecs), 1000);
    repeat (999) cyc(0, 0, 1);
    chk("count_2999", 32'(time_millisecs), 1000);
    cyc(0, 0, 1);
    chk("wait_blank", 32'(time_millisecs), BlankCode);
    delay = m.left;
    repeat (delay - 1) cyc(0, 0, 1);
    chk("wait_led_off", 32'(stimulus_led), 0);
    cyc(0, 0, 1);
    chk("stim_led_on", 32'(stimulus_led), 1);
    chk("stim_time0", 32'(time_millisecs), 0);
    repeat (250) cyc(0, 0, 1);
    cyc(0, 1, 0);
    chk("result_250", 32'(time_millisecs), 250);
    chk("result_led", 32'(stimulus_led), 0);
    cyc(0, 0, 1);
    cyc(0, 1, 1);
    cyc(0, 0, 0);
    chk("result_hold", 32'(time_millisecs), 250);

    // Early react during the blank delay.
    cyc(1, 0, 0);
    chk("restart_3000", 32'(time_millisecs), 3000);
    run_until(M_WAIT, 10000);
    repeat ($urandom_range(1, 500)) cyc(0, 0, rtick());
    cyc(0, 1, rtick());
    chk("early_fail", 32'(time_millisecs), FailCode);
    chk("early_led", 32'(stimulus_led), 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    chk("fail_restart", 32'(time_millisecs), 3000);

    // React and tick in the same clock at 412 ms.
    run_until(M_MEASURE, 15000);
    run_to_ms(412);
    cyc(0, 1, 1);
    chk("same_clock_412", 32'(time_millisecs), 412);

    // Start and react together during the countdown: start aborts.
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat ($urandom_range(10, 2000)) cyc(0, 0, rtick());
    cyc(1, 1, 1);
    chk("abort_idle", 32'(time_millisecs), IdleCode);

    // Timeout with no reaction.
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    run_until(M_MEASURE, 15000);
    repeat (Timeout - 1) cyc(0, 0, 1);
    chk("timeout_9998", 32'(time_millisecs), Timeout - 1);
    chk("timeout_led_on", 32'(stimulus_led), 1);
    cyc(0, 0, 1);
    chk("timeout_fail", 32'(time_millisecs), FailCode);
    chk("timeout_led_off", 32'(stimulus_led), 0);

    // Random button activity, checked by the cycle compare.
    for (int i = 0; i < 6000; i++) begin
      bit s = start_btn;
      bit r = react_btn;
      if ($urandom_range(0, 299) == 0) s = !s;
      if ($urandom_range(0, 99) == 0) r = !r;
      cyc(s, r, rtick());
    end

    // Reset in the middle of a round.
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    repeat ($urandom_range(5, 500)) cyc(0, 0, rtick());
    reset = 1'b1;
    #1;
    chk("midreset_time", 32'(time_millisecs), IdleCode);
    chk("midreset_en", 32'(display_enable), 0);
    cyc(0, 0, 0);
    reset = 1'b0;
    cyc(0, 0, 1);
    chk("post_reset_en", 32'(display_enable), 1);

`ifdef BEST_TIME_EN
    cyc(1, 0, 0);
    run_until(M_MEASURE, 15000);
    run_to_ms(300);
    cyc(0, 1, 0);
    chk("best_r300", 32'(time_millisecs), 300);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    run_until(M_MEASURE, 15000);
    run_to_ms(450);
    cyc(0, 1, 0);
    chk("best_r450", 32'(time_millisecs), 450);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 1);
    cyc(1, 0, 0);
    chk("best_idle_300", 32'(time_millisecs), 300);
    reset = 1'b1;
    #1;
    cyc(0, 0, 0);
    reset = 1'b0;
    cyc(0, 0, 1);
    chk("best_cleared", 32'(time_millisecs), IdleCode);
`endif

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
